// File: rtl/dptr_pkg.sv
// rtl/dptr_pkg.sv - shared types and constants for the datapath instruction sequencer
//
// Holds the sequencer FSM state enum, the R-type opcode/funct encodings the
// sequencer understands, and the legality check used when entry checking is
// compiled in (DPTR_SEQ_ILLEGAL_CHECK_EN).
package dptr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } dptr_state_e;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // True when the word is an R-type instruction the datapath can execute.
  function automatic logic rtype_legal(input logic [31:0] w);
    logic funct_ok;
    case (w[5:0])
      FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: funct_ok = 1'b1;
      default:                                              funct_ok = 1'b0;
    endcase
    return (w[31:26] == OPCODE_RTYPE) && funct_ok;
  endfunction

endpackage

// File: rtl/dptr_prog_buf.sv
// rtl/dptr_prog_buf.sv - DEPTH x 32 program buffer, synchronous write, combinational read
//
// Ports:
//   clk      - write clock
//   we_i     - write enable (already qualified by the sequencer state)
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
// Contents are intentionally not reset.
module dptr_prog_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dptr_sequencer.sv
// rtl/dptr_sequencer.sv - steps a stored R-type program through the datapath and captures ZF
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   start, prog_len        - launch request (sampled in IDLE) and entry count
//   wr_en/wr_addr/wr_data  - program buffer write port (honoured in IDLE/DONE only)
//   ZF_DPTR                - zero flag returned by the datapath
//   instruccion            - registered instruction to the datapath, 0 when idle
//   busy, done             - busy from ISSUE through CAPTURE; one-cycle done pulse
//   zf_mask, zf_count      - captured ZF per entry and its population count
//   illegal_count          - entries skipped as illegal
// Optional feature: define DPTR_SEQ_ILLEGAL_CHECK_EN to skip entries that are
// not supported R-type instructions; otherwise every entry is issued and
// illegal_count stays 0.
module dptr_sequencer #(
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  prog_len,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        ZF_DPTR,
  output logic [31:0] instruccion,
  output logic        busy,
  output logic        done,
  output logic [15:0] zf_mask,
  output logic [4:0]  zf_count,
  output logic [4:0]  illegal_count
);

  import dptr_pkg::*;

  localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_LEN   = 5'(DEPTH);
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYCLES - 1);

  dptr_state_e state_q;
  logic [3:0]  idx_q;
  logic [4:0]  len_q;
  logic [2:0]  settle_q;
  logic [31:0] instr_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] zf_mask_q;
  logic [4:0]  zf_count_q;
  logic [4:0]  illegal_q;

  logic [4:0]  eff_len_d;
  logic        last_entry;
  logic        entry_ok;
  logic        buf_we;
  logic [31:0] rd_data;

  dptr_prog_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_buf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (wr_addr[AW-1:0]),
    .wdata_i (wr_data),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  always_comb begin
    eff_len_d  = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
    last_entry = ({1'b0, idx_q} == (len_q - 5'd1));
    // Writes during a run would change the program under execution, so drop them.
    buf_we     = wr_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`ifdef DPTR_SEQ_ILLEGAL_CHECK_EN
    entry_ok   = rtype_legal(rd_data);
`else
    entry_ok   = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      settle_q   <= '0;
      instr_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zf_mask_q  <= '0;
      zf_count_q <= '0;
      illegal_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q      <= '0;
            len_q      <= eff_len_d;
            zf_mask_q  <= '0;
            zf_count_q <= '0;
            illegal_q  <= '0;
            if (eff_len_d == 5'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              busy_q  <= 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          if (entry_ok) begin
            instr_q  <= rd_data;
            settle_q <= '0;
            state_q  <= ST_SETTLE;
          end else begin
            // Skipped entry: never driven, ZF bit left at 0, one cycle spent.
            instr_q   <= '0;
            illegal_q <= illegal_q + 5'd1;
            idx_q     <= idx_q + 4'd1;
            if (last_entry) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= ST_CAPTURE;
          end else begin
            settle_q <= settle_q + 3'd1;
          end
        end

        ST_CAPTURE: begin
          zf_mask_q[idx_q] <= ZF_DPTR;
          zf_count_q       <= zf_count_q + {4'd0, ZF_DPTR};
          idx_q            <= idx_q + 4'd1;
          instr_q          <= '0;
          if (last_entry) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_ISSUE;
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          instr_q <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instruccion   = instr_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign zf_mask       = zf_mask_q;
  assign zf_count      = zf_count_q;
  // Without the check build the skip branch is unreachable, so this stays 0.
  assign illegal_count = illegal_q;

endmodule

// File: tb/tb_dptr_sequencer.sv
// tb/tb_dptr_sequencer.sv - self-checking bench for dptr_sequencer
module tb_dptr_sequencer;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  prog_len = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        ZF_DPTR;
  logic [31:0] instruccion;
  logic        busy;
  logic        done;
  logic [15:0] zf_mask;
  logic [4:0]  zf_count;
  logic [4:0]  illegal_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dptr_sequencer #(
    .DEPTH         (16),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .prog_len      (prog_len),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .ZF_DPTR       (ZF_DPTR),
    .instruccion   (instruccion),
    .busy          (busy),
    .done          (done),
    .zf_mask       (zf_mask),
    .zf_count      (zf_count),
    .illegal_count (illegal_count)
  );

  // Datapath stand-in: fixed register file, R-type ALU, ZF = (result == 0).
  function automatic logic [31:0] reg_val(input logic [4:0] r);
    case (r)
      5'd9:    return 32'd5;
      5'd15:   return 32'd5;
      5'd20:   return 32'd7;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic dp_zf(input logic [31:0] w);
    logic [31:0] a, b, r;
    a = reg_val(w[25:21]);
    b = reg_val(w[20:16]);
    case (w[5:0])
      6'h20:   r = a + b;
      6'h22:   r = a - b;
      6'h24:   r = a & b;
      6'h25:   r = a | b;
      6'h2A:   r = {31'd0, $signed(a) < $signed(b)};
      default: r = 32'd0;
    endcase
    return (r == 32'd0);
  endfunction

  assign ZF_DPTR = dp_zf(instruccion);

  typedef struct {
    logic [31:0] word;
    bit          legal;
  } entry_t;

  typedef struct {
    int          len;
    bit          interfere;
    int          exp_done;
    logic [15:0] exp_mask;
    logic [4:0]  exp_cnt;
    logic [4:0]  exp_ill;
  } vec_t;

  entry_t prog [16];
  vec_t   vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 4'(i);
      wr_data = prog[i].word;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Launch one vector, compare the per-cycle trace against a timing model
  // built from the program table, then compare the held results.
  task automatic run_vec(input int v, input string tag);
    logic [31:0] exp_i [0:127];
    int n, eff, done_k, bad_k;
    logic [31:0] ei;
    logic eb, ed;
    n = 0;
    eff = (vecs[v].len > 16) ? 16 : vecs[v].len;
    for (int e = 0; e < eff; e++) begin
      exp_i[n] = 32'd0; n++;
      if (prog[e].legal) begin
        for (int s = 0; s < SETTLE + 1; s++) begin
          exp_i[n] = prog[e].word; n++;
        end
      end
    end
    @(negedge clk);
    prog_len = 5'(vecs[v].len);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_k = -1;
    bad_k = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ei = (k < n) ? exp_i[k] : 32'd0;
      eb = (k < n);
      ed = (k == n);
      if (bad_k < 0 && (instruccion !== ei || busy !== eb || done !== ed)) begin
        bad_k = k;
        $display("  %s cycle %0d: instr=%h busy=%b done=%b, model instr=%h busy=%b done=%b",
                 tag, k, instruccion, busy, done, ei, eb, ed);
      end
      if (vecs[v].interfere && k == 10) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0289A022; start = 1'b1;
      end
      if (vecs[v].interfere && k == 11) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    wr_en = 1'b0;
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(done_k), 32'(vecs[v].exp_done));
    check({tag, "_trace_first_bad_cycle"}, 32'(bad_k), 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_zf_mask"}, {16'd0, zf_mask}, {16'd0, vecs[v].exp_mask});
    check({tag, "_zf_count"}, {27'd0, zf_count}, {27'd0, vecs[v].exp_cnt});
    check({tag, "_illegal_count"}, {27'd0, illegal_count}, {27'd0, vecs[v].exp_ill});
  endtask

  initial begin
    int k1, k2, rst_k;

    prog[0] = '{32'h01E9A022, 1'b1};
`ifdef DPTR_SEQ_ILLEGAL_CHECK_EN
    prog[1] = '{32'h8C000000, 1'b0};
`else
    prog[1] = '{32'h0289A022, 1'b1};
`endif
    prog[2] = '{32'h00AF7820, 1'b1};
    prog[3] = '{32'h028FA82A, 1'b1};
    for (int i = 4; i < 16; i++) prog[i] = '{32'h00000020, 1'b1};

`ifdef DPTR_SEQ_ILLEGAL_CHECK_EN
    vecs[0] = '{4,  1'b0, 13, 16'h0009, 5'd2,  5'd1};
    vecs[1] = '{0,  1'b0, 0,  16'h0000, 5'd0,  5'd0};
    vecs[2] = '{1,  1'b0, 4,  16'h0001, 5'd1,  5'd0};
    vecs[3] = '{2,  1'b0, 5,  16'h0001, 5'd1,  5'd1};
    vecs[4] = '{20, 1'b1, 61, 16'hFFF9, 5'd14, 5'd1};
    vecs[5] = '{1,  1'b0, 4,  16'h0001, 5'd1,  5'd0};
    vecs[6] = '{3,  1'b0, 9,  16'h0001, 5'd1,  5'd1};
    rst_k = 6;
`else
    vecs[0] = '{4,  1'b0, 16, 16'h0009, 5'd2,  5'd0};
    vecs[1] = '{0,  1'b0, 0,  16'h0000, 5'd0,  5'd0};
    vecs[2] = '{1,  1'b0, 4,  16'h0001, 5'd1,  5'd0};
    vecs[3] = '{2,  1'b0, 8,  16'h0001, 5'd1,  5'd0};
    vecs[4] = '{20, 1'b1, 64, 16'hFFF9, 5'd14, 5'd0};
    vecs[5] = '{1,  1'b0, 4,  16'h0001, 5'd1,  5'd0};
    vecs[6] = '{3,  1'b0, 12, 16'h0001, 5'd1,  5'd0};
    rst_k = 9;
`endif

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_instr", instruccion, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_zf_mask", {16'd0, zf_mask}, 32'd0);
    check("rst_zf_count", {27'd0, zf_count}, 32'd0);
    check("rst_illegal", {27'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load_prog();

    for (int v = 0; v < 7; v++) begin
      run_vec(v, $sformatf("vec%0d_len%0d", v, vecs[v].len));
    end

    // start held high: DONE -> IDLE -> relaunch.
    @(negedge clk);
    prog_len = 5'd1;
    start = 1'b1;
    @(posedge clk);
    k1 = -1;
    k2 = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (k1 < 0) k1 = k;
        else begin
          k2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("hold_start_first_done", 32'(k1), 32'd4);
    check("hold_start_second_done", 32'(k2), 32'd10);
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset in SETTLE of entry 2, then a clean re-run.
    @(negedge clk);
    prog_len = 5'd4;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k <= rst_k; k++) @(negedge clk);
    check("pre_rst_instr", instruccion, 32'h00AF7820);
    check("pre_rst_zf_mask", {16'd0, zf_mask}, 32'h0001);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instruccion, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_zf_mask", {16'd0, zf_mask}, 32'd0);
    check("mid_rst_zf_count", {27'd0, zf_count}, 32'd0);
    check("mid_rst_illegal", {27'd0, illegal_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0, "rerun_after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
